ps2_key_tracker: RTL

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/ps2_key_tracker_pkg.sv | 32 +++
 rtl/ps2_key_tracker_seg7_hex.sv | 13 +
 rtl/ps2_key_tracker.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ps2_key_tracker_pkg.sv
// rtl/ps2_key_tracker_pkg.sv - shared types, scan-code constants and seven-segment encoding
package ps2_key_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;
    localparam logic [7:0] IGNORE_BAT = 8'hAA;
    localparam logic [7:0] IGNORE_ACK = 8'hFA;

    // Active-high patterns, bit order {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] HEX_SEG [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    function automatic logic [7:0] seg_pattern(
        input logic [3:0] nibble,
        input logic       blank,
        input logic       active_low
    );
        logic [7:0] pat;
        pat = blank ? SEG_BLANK : HEX_SEG[nibble];
        return active_low ? ~pat : pat;
    endfunction

endpackage

// File: rtl/ps2_key_tracker_seg7_hex.sv
// rtl/ps2_key_tracker_seg7_hex.sv - one hex digit to seven-segment pattern with blank and polarity
module seg7_hex
    import ps2_key_tracker_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       active_low,
    output logic [7:0] seg
);

    assign seg = seg_pattern(nibble, blank, active_low);

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 scan-code decoder tracking the held key, press count and hex display
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int CNT_WIDTH      = 8,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int COUNT_REPEAT   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              ps2_data,
    input  logic                    ps2_ready,
    output logic                    ps2_nextdata_n,
    output logic [7:0]              key_code,
    output logic                    key_ext,
    output logic                    key_pressed,
    output logic [CNT_WIDTH-1:0]    key_cnt,
    output logic [8*NUM_DIGITS-1:0] seg_out
);

    localparam int  CW  = 4 * (NUM_DIGITS - 2);
    localparam logic POL = (SEG_ACTIVE_LOW != 0);

    state_t     state;
    logic       ack_n;
    logic [7:0] byte_q;
    logic       ext_pend;
    logic       brk_pend;
    logic       same_key;

    assign same_key = (byte_q == key_code) && (ext_pend == key_ext);

    // Reset must release the pop strobe within the very cycle it is asserted
    assign ps2_nextdata_n = ack_n | rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ack_n       <= 1'b1;
            byte_q      <= 8'h00;
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_pressed <= 1'b0;
            key_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ps2_ready) begin
                        state <= ACK;
                        ack_n <= 1'b0;
                    end
                end
                ACK: begin
                    byte_q <= ps2_data;
                    ack_n  <= 1'b1;
                    state  <= GAP;
                end
                GAP: begin
                    state <= IDLE;
                    if (byte_q == PREFIX_EXT) begin
                        ext_pend <= 1'b1;
                    end else if (byte_q == PREFIX_BRK) begin
                        brk_pend <= 1'b1;
                    end else begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                        if (byte_q == IGNORE_BAT || byte_q == IGNORE_ACK) begin
                            key_pressed <= key_pressed;
                        end else if (brk_pend) begin
                            if (same_key) begin
                                key_pressed <= 1'b0;
                            end
                        end else if (key_pressed && same_key) begin
                            if (COUNT_REPEAT != 0) begin
                                key_cnt <= key_cnt + CNT_WIDTH'(1);
                            end
                        end else begin
                            key_code    <= byte_q;
                            key_ext     <= ext_pend;
                            key_pressed <= 1'b1;
                            key_cnt     <= key_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    ack_n <= 1'b1;
                end
            endcase
        end
    end

    logic [CW-1:0] cnt_ext;

    generate
        if (CNT_WIDTH >= CW) begin : g_cnt_trunc
            assign cnt_ext = key_cnt[CW-1:0];
        end else begin : g_cnt_zext
            assign cnt_ext = {{(CW - CNT_WIDTH){1'b0}}, key_cnt};
        end
    endgenerate

    logic [7:0] digit_seg [NUM_DIGITS];

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            logic [3:0] nib;
            logic       blk;
            if (i == 0) begin : g_lo
                assign nib = key_code[3:0];
                assign blk = ~key_pressed;
            end else if (i == 1) begin : g_hi
                assign nib = key_code[7:4];
                assign blk = ~key_pressed;
            end else begin : g_cnt
                assign nib = cnt_ext[4*(i-2) +: 4];
                assign blk = 1'b0;
            end
            seg7_hex u_seg7 (
                .nibble     (nib),
                .blank      (blk),
                .active_low (POL),
                .seg        (digit_seg[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (rst) begin
                seg_out[8*i +: 8] <= seg_pattern(4'h0, (i < 2), POL);
            end else begin
                seg_out[8*i +: 8] <= digit_seg[i];
            end
        end
    end

endmodule
